// File: rtl/sdio_crc_lanes.sv
// Multi-lane serial CRC engine for the SDIO/SPI data path: accumulates one bit
// per lane per cycle, then serialises the CRC MSB-first or checks a received CRC.
module sdio_crc_lanes #(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter int               LANES  = 1,
  parameter logic [CRC_W-1:0] INIT_A = 16'h0ED1,
  parameter logic [CRC_W-1:0] INIT_B = 16'h2E93
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_a,
  input  logic                     load_b,
  input  logic                     gen_en,
  input  logic [LANES-1:0]         din,
  input  logic                     out_start,
  input  logic                     chk_start,
  input  logic                     step,
  output logic [LANES-1:0]         dout,
  output logic                     dout_vld,
  output logic                     busy,
  output logic                     done,
  output logic [LANES-1:0]         crc_err,
  output logic [LANES*CRC_W-1:0]   crc_reg
);

  localparam int CNT_W = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [LANES-1:0][CRC_W-1:0]     crc_q, crc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [LANES-1:0]                err_q, err_d;
  logic                            done_q, done_d;

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (load_a || load_b) begin
      // Preload aborts silently: no done pulse for an interrupted OUT/CHK.
      crc_d   = load_a ? {LANES{INIT_A}} : {LANES{INIT_B}};
      err_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_start) begin
            state_d = OUT;
            cnt_d   = '0;
          end else if (chk_start) begin
            state_d = CHK;
            cnt_d   = '0;
            err_d   = '0;
          end else if (gen_en) begin
            for (int i = 0; i < LANES; i++) begin
              crc_d[i] = {crc_q[i][CRC_W-2:0], 1'b0}
                       ^ ((din[i] ^ crc_q[i][CRC_W-1]) ? POLY : '0);
            end
          end
        end
        OUT, CHK: begin
          if (step) begin
            for (int i = 0; i < LANES; i++) begin
              if (state_q == CHK) begin
                err_d[i] = err_q[i] | (din[i] ^ crc_q[i][CRC_W-1]);
              end
              crc_d[i] = {crc_q[i][CRC_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  // NOTE: the CRC lane registers are reset too; they are visible outputs with
  // defined reset values, not scratch storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_dout
    assign dout[g] = crc_q[g][CRC_W-1];
  end

  assign dout_vld = (state_q == OUT);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign crc_err  = err_q;
  assign crc_reg  = crc_q;

endmodule

// File: doc/sdio_crc_lanes.md
# sdio_crc_lanes

Parametrised multi-lane serial CRC engine for the SDIO/SPI client data path. It accumulates one bit per lane per cycle into independent CRC registers, with selectable polynomial, width and preload values. It then serialises each CRC MSB-first onto its lane, or compares each CRC against incoming CRC bits and flags mismatches. It sits between the data-line shifters and the block-transfer FSM, and covers 1-bit SPI, 4-bit and 8-bit SD bus modes.

## Interface
- CRC_W, 16, CRC width in bits (range 5..32)
- POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
- LANES, 1, number of independent data lanes/CRC registers (1, 4 or 8)
- INIT_A, 16'h0ED1, preload value applied by load_a
- INIT_B, 16'h2E93, preload value applied by load_b
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- load_a  in  1  preload all lanes with INIT_A, clear crc_err, abort any operation
- load_b  in  1  preload all lanes with INIT_B, same side effects as load_a
- gen_en  in  1  accumulate din into all lanes (IDLE only)
- din  in  LANES  serial data per lane; data bits in IDLE, received CRC bits in CHK
- out_start  in  1  begin serialising CRC (IDLE only)
- chk_start  in  1  begin checking received CRC (IDLE only); clears crc_err
- step  in  1  bit-advance qualifier in OUT/CHK (bus clock enable)
- dout  out  LANES  crc_reg MSB of each lane
- dout_vld  out  1  high while in OUT
- busy  out  1  high in OUT or CHK
- done  out  1  one-cycle pulse after the last CRC bit is shifted or checked
- crc_err  out  LANES  sticky per-lane mismatch flag from CHK
- crc_reg  out  LANES*CRC_W  lane i at [i*CRC_W +: CRC_W]

## Operation
- States: IDLE, OUT, CHK. Bit counter cnt has width $clog2(CRC_W+1).
- Priority each cycle: rst > load_a > load_b > state action.
- rst: all lanes 0, state IDLE, cnt 0, crc_err 0, done 0.
- load_a/load_b in any state: preload all lanes, clear crc_err, go to IDLE. No done is generated; an aborted OUT/CHK is silent.
- IDLE with gen_en=1, per lane: fb = din[i] ^ crc[i][CRC_W-1]; crc[i] <= {crc[i][CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- IDLE start requests:
  - out_start → OUT, cnt 0.
  - chk_start → CHK, cnt 0, crc_err cleared.
  - If both are asserted, out_start wins.
  - Any start in the same cycle as gen_en: the start wins and the gen bit is dropped.
- OUT, on step=1: each lane shifts left with 0 fill, cnt+1. On the step where cnt==CRC_W-1, go to IDLE and register done=1 for one cycle.
- CHK, on step=1:
  - crc_err[i] |= din[i] ^ crc[i][CRC_W-1]; lanes shift left with 0 fill, cnt+1.
  - Same termination and done as OUT.
  - crc_err holds until the next load_a, load_b, chk_start or rst.
- In OUT/CHK, step=0 holds all state. gen_en, out_start and chk_start are ignored while busy.
- After a complete OUT or CHK, every lane register equals 0.

## Timing
- gen_en update is visible on crc_reg/dout the cycle after the enabling edge (1-cycle latency).
- dout is taken directly from register MSBs, with no extra register stage. The first CRC bit is valid in the cycle out_start is sampled; each subsequent bit appears after each step edge.
- busy/dout_vld rise the cycle after the start edge and fall the cycle after the final step edge, coincident with done=1.
- The done pulse is exactly one cycle. back-to-back out_start is accepted in the done cycle.
- crc_err updates the cycle after the step edge that sampled the mismatching bit.
- Reset values: dout 0, dout_vld 0, busy 0, done 0, crc_err 0, crc_reg 0.

## Test plan
- LANES=1, default parameters: rst, feed ASCII "123456789" MSB-first via gen_en, 72 cycles → crc_reg=16'h31C3; out_start plus 16 steps → dout serialises 0x31C3 MSB-first, done one pulse, crc_reg=0.
- LANES=4: each lane fed 512 bytes of 0xFF → each lane 16'h7FA1; chk_start with din carrying 0x7FA1 on all lanes over 16 steps → crc_err=4'b0000, done pulse.
- Same as the previous scenario, but lane 2 receives 0x7FA0 → crc_err=4'b0100 after the final step and held until chk_start.
- load_a → all lanes 16'h0ED1; load_b → 16'h2E93. load_a asserted during OUT at cnt=7 → IDLE, crc_reg=0x0ED1, no done pulse.
- step toggling 1-0-0-1 during OUT: state and dout hold while step=0; done arrives only after 16 asserted steps. out_start and chk_start together → OUT entered.
- rst asserted in CHK with crc_err set → all outputs 0 the next cycle; gen_en in the same cycle as out_start → data bit ignored.
